rotate_sequencer: RTL
=====================

Name: rotate_sequencer

Overview:
- Command sequencer for the team's 8-bit load/rotate/arithmetic-shift register.
- Accepts one command per start pulse (load, rotate-left N, rotate-right N, arithmetic-shift-right N) and steps the register one position per clock until N steps are done.
- Owns the register state, holding it between commands.
- Mirrors the per-cycle control levels (ParallelLoadn / RotateRight / ASRight encoding) on outputs, so a lab board or testbench can display them.

Parameters:
WIDTH, 8, register width in bits
CNT_W, 3, width of step-count field (max steps = 2^CNT_W - 1)

Ports:
clock  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  command strobe, sampled only in IDLE
op  input  2  00 load, 01 rotate left, 10 rotate right, 11 arithmetic shift right
count  input  CNT_W  number of single-bit steps (ignored for load)
data_in  input  WIDTH  parallel load value
q  output  WIDTH  register contents
busy  output  1  high in LOAD and STEP states
done  output  1  one-cycle completion pulse
ctl_parallel_loadn  output  1  0 in the cycle q is parallel-loaded, else 1
ctl_rotate_right  output  1  1 during STEP for op 10/11, else 0
ctl_asright  output  1  1 during STEP for op 11, else 0

Behaviour:
- Single clock "clock"; reset "reset" is synchronous, active-high; all state updates on the rising edge.
- Reset (including mid-command) sets:
  - state IDLE, q=0, busy=0, done=0
  - ctl_parallel_loadn=1, ctl_rotate_right=0, ctl_asright=0
  - latched op/count/data cleared
- Reset overrides start on the same edge.
- States: IDLE, LOAD, STEP, DONE.
- IDLE:
  - q holds.
  - On an edge with start=1: latch op, count, data_in.
  - Next state: op=00 → LOAD; op≠00 and count≠0 → STEP with remaining=count; op≠00 and count=0 → DONE (q unchanged).
- LOAD: ctl_parallel_loadn=0; at the next edge q<=latched data, go to DONE. Latency: start edge + 1 edge.
- STEP: one step per edge, remaining decremented; when remaining=1 at the edge, go to DONE. N steps complete exactly N edges after the start edge.
  - Rotate left: q<={q[W-2:0], q[W-1]}
  - Rotate right: q<={q[0], q[W-1:1]}
  - Arithmetic shift right: q<={q[W-1], q[W-1:1]} (MSB replicated)
- DONE: done=1, busy=0 for exactly one cycle; always return to IDLE. start is ignored in DONE.
- start is ignored while busy. Inputs other than start are don't-care outside the accept edge.
- Control mirror outputs are decoded from the current state and latched op; they are registered-state-driven, with no combinational path from the inputs.
- Width rule: count is unsigned. Steps ≥ WIDTH are legal, so rotates wrap fully and an ASR saturates to all sign bits.

Optional Feature:
- Macro: ROTSEQ_CARRY_EN.
- When defined, a port carry_out (output, 1) is added:
  - Reset value 0; cleared by load.
  - Each step captures the bit shifted off the end: q[W-1] for rotate left, q[0] for rotate right and ASR.
  - Holds in IDLE/DONE. A count=0 command leaves it unchanged.
- When undefined, the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then start op=00 data_in=0xA5 → busy=1 for 1 cycle; q=0xA5 and done=1 on the 2nd cycle after the start edge; ctl_parallel_loadn=0 only in the LOAD cycle.
- Load 0x81, then op=10 count=3 → q sequence 0xC0, 0x60, 0x30; done pulse the cycle after the 3rd step; ctl_rotate_right=1 and ctl_asright=0 for 3 cycles; carry_out=0 when enabled.
- Load 0x90, then op=11 count=2 → q 0xC8 then 0xE4; ctl_asright=1 for 2 cycles. Load 0x01, then op=01 count=7 → q=0x80. Load 0x81, then op=01 count=1 → q=0x03, carry_out=1.
- op=01 count=0 → no STEP; done=1 the cycle after the start edge; q unchanged. A start pulse held during busy and during DONE → no second command, q unaffected.
- Load 0xFF, op=10 count=5, assert reset after 2 steps → next cycle q=0x00, busy=0, done=0, state IDLE; a subsequent load 0x3C proceeds normally.

Source files
------------

// File: rtl/rotate_sequencer_if.sv
// Command/status bundle for rotate_sequencer. The carry_out signal exists only when
// ROTSEQ_CARRY_EN is defined.
interface rotate_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
);
  logic             start;
  logic [1:0]       op;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;
  logic             ctl_parallel_loadn;
  logic             ctl_rotate_right;
  logic             ctl_asright;
`ifdef ROTSEQ_CARRY_EN
  logic             carry_out;

  modport master (
    output start, op, count, data_in,
    input  q, busy, done, ctl_parallel_loadn, ctl_rotate_right, ctl_asright, carry_out
  );
  modport slave (
    input  start, op, count, data_in,
    output q, busy, done, ctl_parallel_loadn, ctl_rotate_right, ctl_asright, carry_out
  );
`else
  modport master (
    output start, op, count, data_in,
    input  q, busy, done, ctl_parallel_loadn, ctl_rotate_right, ctl_asright
  );
  modport slave (
    input  start, op, count, data_in,
    output q, busy, done, ctl_parallel_loadn, ctl_rotate_right, ctl_asright
  );
`endif
endinterface

// File: rtl/rotate_sequencer.sv
// Load/rotate/ASR command sequencer that owns an 8-bit shift register and steps it one position per clock.
// The optional carry_out capture is enabled with the ROTSEQ_CARRY_EN macro.
module rotate_sequencer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  rotate_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, STEP, DONE} state_t;
  typedef enum logic [1:0] {OP_LD = 2'b00, OP_ROL = 2'b01, OP_ROR = 2'b10, OP_ASR = 2'b11} op_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] data;
  } cmd_t;

  state_t           state;
  cmd_t             cmd;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_step;
  logic             busy, done, pl_n, rr, asr;
  logic             carry_step;

  // Next value of each bit for one step, chosen by the latched op.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    localparam int LO = (i + WIDTH - 1) % WIDTH;
    localparam int HI = (i + 1) % WIDTH;
    if (i == WIDTH - 1) begin : g_msb
      always_comb begin
        q_step[i] = q[HI];
        if (cmd.op == OP_ROL)      q_step[i] = q[LO];
        else if (cmd.op == OP_ASR) q_step[i] = q[WIDTH-1];
      end
    end else begin : g_lsb
      assign q_step[i] = (cmd.op == OP_ROL) ? q[LO] : q[HI];
    end
  end

  assign carry_step = (cmd.op == OP_ROL) ? q[WIDTH-1] : q[0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cmd   <= '0;
      q     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pl_n  <= 1'b1;
      rr    <= 1'b0;
      asr   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cmd.op    <= bus.op;
            cmd.count <= bus.count;
            cmd.data  <= bus.data_in;
            if (bus.op == OP_LD) begin
              state <= LOAD;
              busy  <= 1'b1;
              pl_n  <= 1'b0;
            end else if (bus.count != '0) begin
              state <= STEP;
              busy  <= 1'b1;
              rr    <= bus.op[1];
              asr   <= (bus.op == OP_ASR);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        LOAD: begin
          q     <= cmd.data;
          state <= DONE;
          busy  <= 1'b0;
          pl_n  <= 1'b1;
          done  <= 1'b1;
        end
        STEP: begin
          q <= q_step;
          // The latched count doubles as the remaining-steps counter.
          if (cmd.count == CNT_W'(1)) begin
            state <= DONE;
            busy  <= 1'b0;
            rr    <= 1'b0;
            asr   <= 1'b0;
            done  <= 1'b1;
          end else begin
            cmd.count <= cmd.count - CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ROTSEQ_CARRY_EN
  logic carry;

  always_ff @(posedge clock) begin
    if (reset)               carry <= 1'b0;
    else if (state == LOAD)  carry <= 1'b0;
    else if (state == STEP)  carry <= carry_step;
  end

  assign bus.carry_out = carry;
`else
  logic unused_carry;
  assign unused_carry = carry_step;
`endif

  assign bus.q                  = q;
  assign bus.busy               = busy;
  assign bus.done               = done;
  assign bus.ctl_parallel_loadn = pl_n;
  assign bus.ctl_rotate_right   = rr;
  assign bus.ctl_asright        = asr;
endmodule
